// File: rtl/card_dealer.sv
// Deals unique cards 0-51 to the player and dealer requesters from an LFSR source,
// rejecting out-of-range/dealt draws and falling back to a linear scan after MAX_TRIES misses.
module card_dealer #(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [8:0] rnd_i,
    input  logic       shuffle_i,
    input  logic       req_player_i,
    input  logic       req_dealer_i,
    output logic       deal_valid_o,
    output logic       deal_to_o,
    output logic       deal_empty_o,
    output logic [5:0] card_o,
    output logic [3:0] rank_o,
    output logic [1:0] suit_o,
    output logic [5:0] cards_left_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {IDLE, DRAW, SCAN, DONE} state_e;

    localparam logic [5:0] DECK = 6'd52;

    state_e      state_q, state_d;
    logic [51:0] dealt_q, dealt_d;
    logic [5:0]  left_q, left_d;
    logic        last_q, last_d;
    logic [7:0]  tries_q, tries_d;
    logic [5:0]  ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic        to_q, to_d;
    logic        empty_q, empty_d;
    logic [5:0]  card_q, card_d;
    logic [3:0]  rank_q, rank_d;
    logic [1:0]  suit_q, suit_d;

    logic [63:0] taken;
    logic [51:0] mask;
    logic [5:0]  draw_idx, take_idx;
    logic        take, gnt_dealer;
    logic        unused_rnd;

    assign unused_rnd = ^rnd_i[8:6];
    // Indices 52-63 read as already dealt, so one lookup also rejects out-of-range draws.
    assign taken      = {12'hFFF, dealt_q};
    assign draw_idx   = rnd_i[5:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dealt_q <= '0;
            left_q  <= DECK;
            last_q  <= 1'b1;
            tries_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= 1'b0;
            to_q    <= 1'b0;
            empty_q <= 1'b0;
            card_q  <= '0;
            rank_q  <= '0;
            suit_q  <= '0;
        end else begin
            state_q <= state_d;
            dealt_q <= dealt_d;
            left_q  <= left_d;
            last_q  <= last_d;
            tries_q <= tries_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
            empty_q <= empty_d;
            card_q  <= card_d;
            rank_q  <= rank_d;
            suit_q  <= suit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dealt_d    = dealt_q;
        left_d     = left_q;
        last_d     = last_q;
        tries_d    = tries_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        to_d       = to_q;
        empty_d    = empty_q;
        card_d     = card_q;
        rank_d     = rank_q;
        suit_d     = suit_q;
        take       = 1'b0;
        take_idx   = '0;
        gnt_dealer = 1'b0;
        mask       = '0;
        case (state_q)
            IDLE: begin
                if (shuffle_i) begin
                    dealt_d = '0;
                    left_d  = DECK;
                end else if (req_player_i || req_dealer_i) begin
                    gnt_dealer = req_dealer_i && (!req_player_i || !last_q);
                    last_d     = gnt_dealer;
                    gnt_d      = gnt_dealer;
                    tries_d    = '0;
                    if (left_q == '0) begin
                        state_d = DONE;
                        to_d    = gnt_dealer;
                        empty_d = 1'b1;
                        card_d  = '0;
                        rank_d  = 4'd1;
                        suit_d  = '0;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                if (!taken[draw_idx]) begin
                    take     = 1'b1;
                    take_idx = draw_idx;
                end else begin
                    tries_d = tries_q + 8'd1;
                    if (tries_d == 8'(MAX_TRIES)) begin
                        ptr_d   = (draw_idx < DECK) ? draw_idx : draw_idx - DECK;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!taken[ptr_q]) begin
                    take     = 1'b1;
                    take_idx = ptr_q;
                end else begin
                    ptr_d = (ptr_q == 6'd51) ? '0 : ptr_q + 6'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (take) begin
            mask    = 52'd1 << take_idx;
            dealt_d = dealt_q | mask;
            left_d  = left_q - 6'd1;
            card_d  = take_idx;
            rank_d  = 4'(take_idx % 6'd13 + 6'd1);
            suit_d  = 2'(take_idx / 6'd13);
            to_d    = gnt_q;
            empty_d = 1'b0;
            state_d = DONE;
        end
    end

    always_comb begin
        deal_valid_o = (state_q == DONE);
        busy_o       = (state_q != IDLE);
        deal_to_o    = to_q;
        deal_empty_o = empty_q;
        card_o       = card_q;
        rank_o       = rank_q;
        suit_o       = suit_q;
        cards_left_o = left_q;
    end

endmodule
